// File: rtl/axil_config_master_if.sv
// AXI4-Lite channel bundle used between axil_config_master and the
// configuration slave.
//   master modport: drives aw/w/ar payload+valid, bready, rready
//   slave  modport: drives awready, wready, arready, b/r payload+valid
interface axil_config_master_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64
);
  logic [ADDR_BITS-1:0]   awaddr;
  logic [2:0]             awprot;
  logic                   awvalid;
  logic                   awready;
  logic [DATA_BITS-1:0]   wdata;
  logic [DATA_BITS/8-1:0] wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [ADDR_BITS-1:0]   araddr;
  logic [2:0]             arprot;
  logic                   arvalid;
  logic                   arready;
  logic [DATA_BITS-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_config_master.sv
// AXI4-Lite initiator for the configuration address space.
// Turns one command (register index, data, read/write) into a single
// AXI4-Lite transaction and returns exactly one response per command.
// Only one transaction is ever outstanding; an optional response timeout
// reports error 2'b11 and then drains the late AXI beat silently.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cmd_valid/ready/write/reg/data    command stream in
//   rsp_valid/ready/write/data/error  response stream out (registered)
//   axi_ctrl                          AXI4-Lite master port
module axil_config_master #(
  parameter int REG_IDX_BITS   = 16,
  parameter int ADDR_LSB       = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AXIL_ADDR_BITS = 32,
  parameter int AXIL_DATA_BITS = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [REG_IDX_BITS-1:0]   cmd_reg,
  input  logic [AXIL_DATA_BITS-1:0] cmd_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [AXIL_DATA_BITS-1:0] rsp_data,
  output logic [1:0]                rsp_error,
  axil_config_master_if.master      axi_ctrl
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP, DRAIN} state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_t                    state_reg, state_next;
  logic                      awvalid_reg, awvalid_next, wvalid_reg, wvalid_next;
  logic                      arvalid_reg, arvalid_next;
  logic                      bready_reg, bready_next, rready_reg, rready_next;
  logic                      aw_done_reg, aw_done_next, w_done_reg, w_done_next;
  logic [AXIL_ADDR_BITS-1:0] awaddr_reg, awaddr_next, araddr_reg, araddr_next;
  logic [AXIL_DATA_BITS-1:0] wdata_reg, wdata_next;
  logic                      rsp_valid_reg, rsp_valid_next, rsp_write_reg, rsp_write_next;
  logic [AXIL_DATA_BITS-1:0] rsp_data_reg, rsp_data_next;
  logic [1:0]                rsp_error_reg, rsp_error_next;
  logic [15:0]               tmo_cnt_reg, tmo_cnt_next;

  logic                      aw_hs, w_hs, ar_hs, b_hs, r_hs, tmo_hit, go_tmo;
  logic [AXIL_ADDR_BITS-1:0] cmd_addr;

  assign cmd_addr = AXIL_ADDR_BITS'({cmd_reg, {ADDR_LSB{1'b0}}});
  assign aw_hs    = awvalid_reg & axi_ctrl.awready;
  assign w_hs     = wvalid_reg & axi_ctrl.wready;
  assign ar_hs    = arvalid_reg & axi_ctrl.arready;
  assign b_hs     = bready_reg & axi_ctrl.bvalid;
  assign r_hs     = rready_reg & axi_ctrl.rvalid;
  assign tmo_hit  = TMO_EN && (tmo_cnt_reg == TMO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      bready_reg    <= 1'b0;
      rready_reg    <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      awaddr_reg    <= '0;
      araddr_reg    <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_error_reg <= 2'b00;
      tmo_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      arvalid_reg   <= arvalid_next;
      bready_reg    <= bready_next;
      rready_reg    <= rready_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      awaddr_reg    <= awaddr_next;
      araddr_reg    <= araddr_next;
      wdata_reg     <= wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_write_reg <= rsp_write_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_error_reg <= rsp_error_next;
      tmo_cnt_reg   <= tmo_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    arvalid_next   = arvalid_reg;
    bready_next    = bready_reg;
    rready_next    = rready_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    awaddr_next    = awaddr_reg;
    araddr_next    = araddr_reg;
    wdata_next     = wdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_write_next = rsp_write_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_error_next = rsp_error_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    go_tmo         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          tmo_cnt_next   = '0;
          rsp_write_next = cmd_write;
          rsp_data_next  = '0;
          rsp_error_next = 2'b00;
          if (cmd_write) begin
            awaddr_next  = cmd_addr;
            wdata_next   = cmd_data;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            bready_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
            state_next   = WR_REQ;
          end else begin
            araddr_next  = cmd_addr;
            arvalid_next = 1'b1;
            rready_next  = 1'b1;
            state_next   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        tmo_cnt_next = tmo_cnt_reg + 16'd1;
        if (aw_hs) begin
          awvalid_next = 1'b0;
          aw_done_next = 1'b1;
        end
        if (w_hs) begin
          wvalid_next = 1'b0;
          w_done_next = 1'b1;
        end
        // An early B beat is captured here; bready dropping marks it as seen.
        if (b_hs) begin
          bready_next    = 1'b0;
          rsp_error_next = axi_ctrl.bresp;
        end
        if (aw_done_next && w_done_next) begin
          if (!bready_next) begin
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end else if (tmo_hit) begin
            go_tmo = 1'b1;
          end else begin
            state_next = WR_RESP;
          end
        end else if (tmo_hit) begin
          go_tmo = 1'b1;
        end
      end
      WR_RESP: begin
        tmo_cnt_next = tmo_cnt_reg + 16'd1;
        if (b_hs) begin
          bready_next    = 1'b0;
          rsp_error_next = axi_ctrl.bresp;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else if (tmo_hit) begin
          go_tmo = 1'b1;
        end
      end
      RD_REQ, RD_RESP: begin
        tmo_cnt_next = tmo_cnt_reg + 16'd1;
        if (ar_hs) arvalid_next = 1'b0;
        if (r_hs) begin
          // An R beat implies the address was taken, so arvalid is done too.
          arvalid_next   = 1'b0;
          rready_next    = 1'b0;
          rsp_data_next  = axi_ctrl.rdata;
          rsp_error_next = axi_ctrl.rresp;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else if (tmo_hit) begin
          go_tmo = 1'b1;
        end else if (ar_hs) begin
          state_next = RD_RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      DRAIN: begin
        // Let every pending beat finish; the late B/R payload is dropped.
        if (aw_hs) awvalid_next = 1'b0;
        if (w_hs)  wvalid_next  = 1'b0;
        if (ar_hs) arvalid_next = 1'b0;
        if (b_hs)  bready_next  = 1'b0;
        if (r_hs)  rready_next  = 1'b0;
        if (rsp_ready) rsp_valid_next = 1'b0;
        if (!(awvalid_next | wvalid_next | arvalid_next | bready_next |
              rready_next | rsp_valid_next))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (go_tmo) begin
      rsp_valid_next = 1'b1;
      rsp_error_next = 2'b11;
      rsp_data_next  = '0;
      state_next     = DRAIN;
    end
  end

  assign cmd_ready        = (state_reg == IDLE) & !rst;
  assign rsp_valid        = rsp_valid_reg;
  assign rsp_write        = rsp_write_reg;
  assign rsp_data         = rsp_data_reg;
  assign rsp_error        = rsp_error_reg;
  assign axi_ctrl.awaddr  = awaddr_reg;
  assign axi_ctrl.awprot  = 3'b000;
  assign axi_ctrl.awvalid = awvalid_reg;
  assign axi_ctrl.wdata   = wdata_reg;
  assign axi_ctrl.wstrb   = '1;
  assign axi_ctrl.wvalid  = wvalid_reg;
  assign axi_ctrl.bready  = bready_reg;
  assign axi_ctrl.araddr  = araddr_reg;
  assign axi_ctrl.arprot  = 3'b000;
  assign axi_ctrl.arvalid = arvalid_reg;
  assign axi_ctrl.rready  = rready_reg;
endmodule
